// File: rtl/shift_collector.sv
// Serial-to-parallel receiver: assembles W-bit words (MSB- or LSB-first) into a one-entry valid/ready output buffer.
// Optional even-parity check on a trailing bit is compiled in with `define PARITY_CHECK_EN.
module shift_collector #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         dir,
  input  logic         clr,
  output logic [W-1:0] o,
  output logic         o_valid,
  input  logic         o_ready,
  output logic         ovr,
  output logic         par_err
);

  localparam int CW = $clog2(W + 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t         state_q;
  logic [W-1:0]   sr_q;
  logic [W-1:0]   sr_d;
  logic [CW-1:0]  cnt_q;
  logic           dir_q;
  logic           dir_eff;
  logic           last_bit;
  logic           deliver;
  logic [W-1:0]   word_d;
  logic           perr_d;
  logic [W-1:0]   o_q;
  logic           o_valid_q;
  logic           ovr_q;
  logic           par_err_q;

  // The first bit of a word uses the live dir input; later bits use the latched order.
  always_comb begin
    dir_eff  = (state_q == IDLE) ? dir : dir_q;
    sr_d     = dir_eff ? {sin, sr_q[W-1:1]} : {sr_q[W-2:0], sin};
    last_bit = (cnt_q == CW'(W - 1));
    deliver  = 1'b0;
    word_d   = sr_d;
    perr_d   = 1'b0;
    if (!clr && sin_valid) begin
      case (state_q)
`ifdef PARITY_CHECK_EN
        PAR: begin
          deliver = 1'b1;
          word_d  = sr_q;
          perr_d  = ^{sr_q, sin};
        end
`else
        SHIFT: deliver = last_bit;
`endif
        default: deliver = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      ovr_q     <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      if (clr) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        ovr_q   <= 1'b0;
      end else if (sin_valid) begin
        case (state_q)
          IDLE: begin
            dir_q   <= dir;
            sr_q    <= sr_d;
            cnt_q   <= CW'(1);
            state_q <= SHIFT;
          end
          SHIFT: begin
            sr_q <= sr_d;
            if (last_bit) begin
`ifdef PARITY_CHECK_EN
              cnt_q   <= CW'(W);
              state_q <= PAR;
`else
              cnt_q   <= '0;
              state_q <= IDLE;
`endif
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        endcase
      end

      // A completed word that finds the buffer full and not being drained is dropped.
      if (deliver) begin
        if (!o_valid_q || o_ready) begin
          o_q       <= word_d;
          o_valid_q <= 1'b1;
          par_err_q <= perr_d;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (o_valid_q && o_ready) begin
        o_valid_q <= 1'b0;
      end
    end
  end

  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign ovr     = ovr_q;
  assign par_err = par_err_q;

endmodule

// File: tb/tb_shift_collector.sv
// Self-checking bench for shift_collector: table-driven words with a scoreboard queue,
// plus hand-written overrun/clr, abort and reset-mid-word sequences.
module tb_shift_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic       sin_valid;
  logic       dir;
  logic       clr;
  logic [7:0] o;
  logic       o_valid;
  logic       o_ready;
  logic       ovr;
  logic       par_err;

  int checks = 0;
  int errors = 0;

`ifdef PARITY_CHECK_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  typedef struct {
    logic [7:0] seq;    // bit sequence on the wire, seq[7] sent first
    logic       d;
    int         gap;
    logic       flip;   // toggle dir after the first bit
    logic       pb;
    logic [7:0] exp_o;
    logic       exp_pe;
  } vec_t;

  typedef struct {
    logic [7:0] o;
    logic       pe;
  } exp_t;

  vec_t vecs[7];
  exp_t q[$];
  exp_t e;

  shift_collector #(.W(8)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .dir(dir), .clr(clr),
    .o(o), .o_valid(o_valid), .o_ready(o_ready), .ovr(ovr), .par_err(par_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] seq, input logic d, input int gap,
                      input logic flip, input logic pb);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sin       = seq[7-i];
      sin_valid = 1'b1;
      dir       = (flip && i > 0) ? ~d : d;
      if (i < 7 || PAR_ON) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          sin_valid = 1'b0;
          sin       = ~sin;
        end
      end
    end
    if (PAR_ON) begin
      @(negedge clk);
      sin       = pb;
      sin_valid = 1'b1;
    end
    @(posedge clk);
    #1 sin_valid = 1'b0;
  endtask

  // Scoreboard: every accepted output word must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && o_valid && o_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL extra_word actual=%0h required=none", o);
      end else begin
        e = q.pop_front();
        if (o !== e.o || par_err !== e.pe) begin
          errors++;
          $display("FAIL word actual=%0h/pe%0b required=%0h/pe%0b", o, par_err, e.o, e.pe);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h1E, 1'b0, 0, 1'b0, 1'b0, 8'h1E, 1'b0};
    vecs[1] = '{8'h1E, 1'b1, 0, 1'b0, 1'b0, 8'h78, 1'b0};
    vecs[2] = '{8'hA5, 1'b0, 1, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[3] = '{8'hC1, 1'b1, 0, 1'b0, 1'b1, 8'h83, 1'b0};
    vecs[4] = '{8'hA5, 1'b0, 0, 1'b0, 1'b1, 8'hA5, PAR_ON};
    vecs[5] = '{8'h12, 1'b1, 2, 1'b0, 1'b0, 8'h48, 1'b0};
    vecs[6] = '{8'hF0, 1'b0, 0, 1'b1, 1'b0, 8'hF0, 1'b0};

    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; dir = 1'b0; clr = 1'b0; o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o", 32'(o), 32'h0);
    chk("rst_o_valid", 32'(o_valid), 32'h0);
    chk("rst_ovr", 32'(ovr), 32'h0);
    chk("rst_par_err", 32'(par_err), 32'h0);
    @(negedge clk) rst = 1'b0;

    foreach (vecs[i]) begin
      q.push_back('{vecs[i].exp_o, vecs[i].exp_pe});
      send(vecs[i].seq, vecs[i].d, vecs[i].gap, vecs[i].flip, vecs[i].pb);
      chk($sformatf("lat_valid_%0d", i), 32'(o_valid), 32'h1);
      chk($sformatf("lat_o_%0d", i), 32'(o), 32'(vecs[i].exp_o));
    end
    repeat (2) @(negedge clk);

    // Overrun with a stalled consumer, then clr.
    o_ready = 1'b0;
    send(8'h1E, 1'b0, 0, 1'b0, 1'b0);
    send(8'hA5, 1'b0, 0, 1'b0, 1'b0);
    chk("ovr_o", 32'(o), 32'h1E);
    chk("ovr_flag", 32'(ovr), 32'h1);
    chk("ovr_valid", 32'(o_valid), 32'h1);
    @(negedge clk) clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk("clr_ovr", 32'(ovr), 32'h0);
    chk("clr_o", 32'(o), 32'h1E);
    chk("clr_valid", 32'(o_valid), 32'h1);
    q.push_back('{8'h1E, 1'b0});
    o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("drain_valid", 32'(o_valid), 32'h0);

    // Partial word aborted by clr while a bit is offered in the same cycle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); sin = 1'b1; sin_valid = 1'b1; dir = 1'b0;
    end
    @(negedge clk) clr = 1'b1;
    @(negedge clk) begin clr = 1'b0; sin_valid = 1'b0; end
    q.push_back('{8'h66, 1'b0});
    send(8'h66, 1'b0, 0, 1'b0, 1'b0);
    chk("clr_abort_o", 32'(o), 32'h66);

    // Reset mid-word.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); sin = 1'b1; sin_valid = 1'b1; dir = 1'b0;
    end
    @(negedge clk) sin_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk("midrst_valid", 32'(o_valid), 32'h0);
    #1 rst = 1'b0;
    q.push_back('{8'h3C, 1'b0});
    send(8'h3C, 1'b0, 0, 1'b0, 1'b0);
    chk("midrst_o", 32'(o), 32'h3C);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
